// File: rtl/pulse_pkg.sv
// pulse_pkg: shared types and constants for the pulse width receiver.
//   state_t  - receiver FSM state encoding (also exported on the debug port)
//   WIDTH_W  - width of the measured-width and error-count datapaths
package pulse_pkg;

  localparam int WIDTH_W = 8;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    MEASURE  = 2'd2,
    OVERRUN  = 2'd3
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: loadable up-counter that sticks at all-ones.
// Ports:
//   clock, reset - rising-edge clock, asynchronous active-high reset (count -> 0)
//   clr          - synchronous clear to zero (highest priority)
//   load         - synchronous load of load_val
//   load_val     - value loaded when load is high
//   inc          - increment by one, holding at all-ones
//   count        - current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pulse_rx.sv
// pulse_rx: measures the high time of a synchronous pulse and classifies it
// against PULSE_WIDTH +/- TOLERANCE.
// Ports:
//   clock      - rising-edge clock
//   reset      - asynchronous active-high reset
//   pulse      - measured input, already synchronous to clock
//   valid      - one-cycle strobe, a measurement completed
//   width      - measured high time in cycles, saturating at 255 (held)
//   ok         - last width inside the accepted range (held)
//   err_short  - last width below the accepted range (held)
//   err_long   - last width above the accepted range (held)
//   err_count  - saturating count of rejected pulses since reset
//   state_dbg  - current FSM state, for observation only
// Handshake: valid is a pure strobe with no ready; width/ok/err_* are
// qualified by valid in the cycle it is high and then hold until the next one.
module pulse_rx
  import pulse_pkg::*;
#(
  parameter int PULSE_WIDTH = 5,
  parameter int TOLERANCE   = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pulse,
  output logic               valid,
  output logic [WIDTH_W-1:0] width,
  output logic               ok,
  output logic               err_short,
  output logic               err_long,
  output logic [WIDTH_W-1:0] err_count,
  output logic [1:0]         state_dbg
);

  // Accepted range bounds; both fit in WIDTH_W bits for legal parameters.
  localparam logic [WIDTH_W:0]   HI_BOUND = (WIDTH_W+1)'(PULSE_WIDTH + TOLERANCE);
  localparam logic [WIDTH_W-1:0] LO_BOUND = WIDTH_W'(PULSE_WIDTH - TOLERANCE);

  state_t             state_q, state_d;
  logic               valid_q, valid_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               ok_q, ok_d;
  logic               short_q, short_d;
  logic               long_q, long_d;

  logic [WIDTH_W-1:0] cnt;
  logic               cnt_load;
  logic               cnt_inc;
  logic [WIDTH_W:0]   cnt_next;
  logic               report;
  logic               cls_short;
  logic               cls_long;
  logic               err_inc;

  // Value the counter takes on an increment, one bit wider so the
  // overrun compare cannot wrap.
  assign cnt_next = {1'b0, cnt} + 1'b1;

  assign cls_short = (cnt < LO_BOUND);
  assign cls_long  = ({1'b0, cnt} > HI_BOUND);

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    report   = 1'b0;
    unique case (state_q)
      WAIT_LOW: begin
        // A pulse already high when reset drops is never measured.
        if (!pulse) state_d = IDLE;
      end
      IDLE: begin
        if (pulse) begin
          cnt_load = 1'b1;
          state_d  = MEASURE;
        end
      end
      MEASURE: begin
        if (pulse) begin
          cnt_inc = 1'b1;
          if (cnt_next > HI_BOUND) state_d = OVERRUN;
        end else begin
          report  = 1'b1;
          state_d = IDLE;
        end
      end
      OVERRUN: begin
        if (pulse) begin
          cnt_inc = 1'b1;
        end else begin
          report  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  // Report registers: valid strobes, the rest hold until the next report.
  always_comb begin
    valid_d = report;
    width_d = width_q;
    ok_d    = ok_q;
    short_d = short_q;
    long_d  = long_q;
    if (report) begin
      width_d = cnt;
      short_d = cls_short;
      long_d  = cls_long;
      ok_d    = !cls_short && !cls_long;
    end
  end

  assign err_inc = report && (cls_short || cls_long);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_LOW;
      valid_q <= 1'b0;
      width_q <= '0;
      ok_q    <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      width_q <= width_d;
      ok_q    <= ok_d;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  sat_counter #(.W(WIDTH_W)) u_width_cnt (
    .clock    (clock),
    .reset    (reset),
    .clr      (1'b0),
    .load     (cnt_load),
    .load_val (WIDTH_W'(1)),
    .inc      (cnt_inc),
    .count    (cnt)
  );

  sat_counter #(.W(WIDTH_W)) u_err_cnt (
    .clock    (clock),
    .reset    (reset),
    .clr      (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .inc      (err_inc),
    .count    (err_count)
  );

  assign valid     = valid_q;
  assign width     = width_q;
  assign ok        = ok_q;
  assign err_short = short_q;
  assign err_long  = long_q;
  assign state_dbg = state_q;

  a_valid_single : assert property (@(posedge clock) disable iff (reset)
    valid_q |=> !valid_q);

  a_class_onehot : assert property (@(posedge clock) disable iff (reset)
    valid_q |-> $onehot({ok_q, short_q, long_q}));

endmodule

// File: tb/tb_pulse_rx.sv
// tb_pulse_rx: directed table, hand-written corner sequences and randomized
// pulse trains for pulse_rx (PULSE_WIDTH=5, TOLERANCE=0).
module tb_pulse_rx;

  localparam int PW  = 5;
  localparam int TOL = 0;
  localparam int W   = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         pulse;
  logic         valid;
  logic [W-1:0] width;
  logic         ok;
  logic         err_short;
  logic         err_long;
  logic [W-1:0] err_count;
  logic [1:0]   state_dbg;

  pulse_rx #(.PULSE_WIDTH(PW), .TOLERANCE(TOL)) dut (
    .clock     (clock),
    .reset     (reset),
    .pulse     (pulse),
    .valid     (valid),
    .width     (width),
    .ok        (ok),
    .err_short (err_short),
    .err_long  (err_long),
    .err_count (err_count),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Works purely on the sampled pulse level: tracks whether a low has been
  // seen since reset and the length of the current high run.
  logic [W-1:0] exp_q[$];
  bit  armed;
  int  run_len;
  bit  m_valid;
  int  m_width, m_ok, m_short, m_long, m_err;

  function automatic void model_reset();
    armed   = 0;
    run_len = 0;
    m_valid = 0;
    m_width = 0; m_ok = 0; m_short = 0; m_long = 0; m_err = 0;
    exp_q.delete();
  endfunction

  function automatic void model_sample(input logic p);
    int w;
    m_valid = 0;
    if (reset) return;
    if (!armed) begin
      if (!p) armed = 1;
    end else if (p) begin
      run_len++;
    end else if (run_len > 0) begin
      w = (run_len > 255) ? 255 : run_len;
      m_valid = 1;
      m_width = w;
      m_short = (w < PW - TOL) ? 1 : 0;
      m_long  = (w > PW + TOL) ? 1 : 0;
      m_ok    = (m_short == 0 && m_long == 0) ? 1 : 0;
      if (!m_ok && m_err < 255) m_err++;
      exp_q.push_back(W'(w));
      run_len = 0;
    end
  endfunction

  // ---------------- scoreboard ----------------
  int           got_rep;
  logic [W-1:0] last_w;
  logic         last_ok, last_sh, last_lg;

  function automatic void check_outputs();
    logic [W-1:0] ew;
    chk("valid", int'(valid), int'(m_valid));
    if (valid) begin
      got_rep++;
      last_w  = width;
      last_ok = ok;
      last_sh = err_short;
      last_lg = err_long;
      if (exp_q.size() == 0) begin
        chk("unexpected_report", 1, 0);
      end else begin
        ew = exp_q.pop_front();
        chk("report_width", int'(width), int'(ew));
      end
    end
    chk("width_held", int'(width), m_width);
    chk("ok_held", int'(ok), m_ok);
    chk("short_held", int'(err_short), m_short);
    chk("long_held", int'(err_long), m_long);
    chk("err_count", int'(err_count), m_err);
  endfunction

  // ---------------- driver ----------------
  // Entered and left at a falling edge.
  task automatic cycle(input logic p);
    pulse = p;
    @(posedge clock);
    model_sample(p);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", int'(valid), 0);
    chk("rst_width", int'(width), 0);
    chk("rst_ok", int'(ok), 0);
    chk("rst_short", int'(err_short), 0);
    chk("rst_long", int'(err_long), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_state", int'(state_dbg), 0);
    chk("rst_counter", int'(dut.cnt), 0);
  endtask

  task automatic run_pulse(input int hi, input int lo);
    for (int i = 0; i < hi; i++) cycle(1'b1);
    for (int i = 0; i < lo; i++) cycle(1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int           hi;
    int           lo;
    logic [W-1:0] w;
    logic         ok;
    logic         sh;
    logic         lg;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int hi, lo;
    vecs[0] = '{hi: 5,   lo: 2, w: 8'd5,   ok: 1'b1, sh: 1'b0, lg: 1'b0};
    vecs[1] = '{hi: 3,   lo: 2, w: 8'd3,   ok: 1'b0, sh: 1'b1, lg: 1'b0};
    vecs[2] = '{hi: 8,   lo: 2, w: 8'd8,   ok: 1'b0, sh: 1'b0, lg: 1'b1};
    vecs[3] = '{hi: 300, lo: 2, w: 8'd255, ok: 1'b0, sh: 1'b0, lg: 1'b1};
    vecs[4] = '{hi: 1,   lo: 1, w: 8'd1,   ok: 1'b0, sh: 1'b1, lg: 1'b0};
    vecs[5] = '{hi: 5,   lo: 1, w: 8'd5,   ok: 1'b1, sh: 1'b0, lg: 1'b0};
    vecs[6] = '{hi: 5,   lo: 1, w: 8'd5,   ok: 1'b1, sh: 1'b0, lg: 1'b0};
    vecs[7] = '{hi: 4,   lo: 3, w: 8'd4,   ok: 1'b0, sh: 1'b1, lg: 1'b0};
    vecs[8] = '{hi: 6,   lo: 1, w: 8'd6,   ok: 1'b0, sh: 1'b0, lg: 1'b1};

    pulse = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    apply_reset();
    cycle(1'b0);
    reset = 1'b0;
    cycle(1'b0);
    cycle(1'b0);

    // first two entries pin err_count after the 5- and 3-cycle pulses
    for (int i = 0; i < 9; i++) begin
      got_rep = 0;
      run_pulse(vecs[i].hi, vecs[i].lo);
      chk($sformatf("vec%0d_reports", i), got_rep, 1);
      chk($sformatf("vec%0d_width", i), int'(last_w), int'(vecs[i].w));
      chk($sformatf("vec%0d_ok", i), int'(last_ok), int'(vecs[i].ok));
      chk($sformatf("vec%0d_short", i), int'(last_sh), int'(vecs[i].sh));
      chk($sformatf("vec%0d_long", i), int'(last_lg), int'(vecs[i].lg));
      if (i == 0) chk("err_after_ok", int'(err_count), 0);
      if (i == 1) chk("err_after_short", int'(err_count), 1);
    end

    // overrun is entered exactly on the sixth high sample
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1);
      if (i == 5) chk("state_measure_at5", int'(state_dbg), 2);
      if (i == 6) chk("state_overrun_at6", int'(state_dbg), 3);
    end
    cycle(1'b0);
    chk("overrun_report_idle", int'(state_dbg), 1);
    cycle(1'b0);

    // reset on the third high cycle discards the pulse
    got_rep = 0;
    cycle(1'b1);
    cycle(1'b1);
    pulse = 1'b1;
    apply_reset();
    cycle(1'b1);
    cycle(1'b1);
    reset = 1'b0;
    // pulse still high on release: must not be reported
    for (int i = 0; i < 4; i++) cycle(1'b1);
    chk("wait_low_state", int'(state_dbg), 0);
    cycle(1'b0);
    cycle(1'b0);
    chk("no_report_after_reset", got_rep, 0);
    run_pulse(5, 2);
    chk("post_reset_reports", got_rep, 1);
    chk("post_reset_ok", int'(last_ok), 1);
    chk("post_reset_err", int'(err_count), 0);

    // randomized pulse trains against the model
    for (int i = 0; i < 150; i++) begin
      hi = ($urandom_range(0, 19) == 0) ? $urandom_range(250, 270)
                                        : $urandom_range(1, 12);
      lo = $urandom_range(1, 3);
      run_pulse(hi, lo);
    end
    cycle(1'b0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
